// File: rtl/serial_alu_ctrl.sv
// Bit-serial AND/OR/ADD/SUB sequencer driving an external one-bit ALU slice,
// LSB first, with a start/done handshake and registered result and flags.
`timescale 1ns/1ps
module serial_alu_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_invert_b,
    output logic             slice_cin,
    output logic [1:0]       slice_operation,
    input  logic             slice_result,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [1:0]  OP_SUB = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept_c;
    logic             last_c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_nxt_c;
    logic             carry;
    logic [1:0]       op_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; start only counts in IDLE or DONE
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    accept_c  = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = S_DONE;
                    last_c    = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    accept_c  = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign r_nxt_c = {slice_result, r_sh[WIDTH-1:1]};

    // Operand shifters, carry chain, and completion capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            carry     <= 1'b0;
            op_q      <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
            if (accept_c) begin
                a_sh  <= a_in;
                b_sh  <= b_in;
                op_q  <= op;
                cnt   <= '0;
                carry <= (op == OP_SUB);
            end else if (state == S_RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                r_sh  <= r_nxt_c;
                carry <= slice_cout;
                cnt   <= cnt + CW'(1);
                if (last_c) begin
                    // carry still holds the carry into the MSB here
                    result    <= r_nxt_c;
                    zero      <= (r_nxt_c == '0);
                    carry_out <= op_q[1] & slice_cout;
                    overflow  <= op_q[1] & (carry ^ slice_cout);
                end
            end
        end
    end

    // Slice drive: data bits only while running, control from latched op
    always_comb begin
        slice_a         = 1'b0;
        slice_b         = 1'b0;
        slice_cin       = 1'b0;
        slice_invert_b  = (op_q == OP_SUB);
        slice_operation = op_q[1] ? 2'b10 : {1'b0, op_q[0]};
        if (state == S_RUN) begin
            slice_a   = a_sh[0];
            slice_b   = b_sh[0];
            slice_cin = carry;
        end
    end

endmodule
